// File: rtl/cacheline_adaptor_if.sv
// Bundle of arbiter-side line signals and memory-side burst signals for the cache line adaptor.
// The slave modport is the adaptor's view; master is the view of whatever drives it.
interface cacheline_adaptor_if;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic         resp_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;

   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit line reads/writes into four 64-bit memory beats, lowest beat first.
// Define ADAPTOR_FAST_RESP_EN to respond on the fourth beat instead of a separate DONE cycle.
module cacheline_adaptor (
   input logic              clk,
   input logic              rst,
   cacheline_adaptor_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t       state, state_n;
   logic [1:0]   cnt, cnt_n;
   logic [31:0]  addr;
   logic [255:0] data;
   logic [255:0] line_q;
   logic [63:0]  cur_beat;
   logic         start_rd, start_wr, beat, last_beat, hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      start_rd  = 1'b0;
      start_wr  = 1'b0;
      beat      = 1'b0;
      last_beat = 1'b0;
      case (state)
         IDLE: begin
            // A write wins when both requests are raised together
            if (!hold) begin
               if (bus.write_i) begin
                  state_n  = WRITE;
                  start_wr = 1'b1;
                  cnt_n    = 2'd0;
               end else if (bus.read_i) begin
                  state_n  = READ;
                  start_rd = 1'b1;
                  cnt_n    = 2'd0;
               end
            end
         end
         READ, WRITE: begin
            if (bus.resp_i) begin
               beat  = 1'b1;
               cnt_n = cnt + 2'd1;
               if (cnt == 2'd3) begin
                  last_beat = 1'b1;
`ifdef ADAPTOR_FAST_RESP_EN
                  state_n = IDLE;
`else
                  state_n = DONE;
`endif
               end
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      cur_beat = data[{cnt, 6'd0} +: 64];
   end

`ifdef ADAPTOR_FAST_RESP_EN
   // Blocks new requests for the IDLE cycle right after a fast response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= 1'b0;
      end else begin
         hold <= last_beat;
      end
   end
`else
   assign hold = 1'b0;
`endif

   // The data register holds the write line, or the read line being assembled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr   <= 32'd0;
         data   <= 256'd0;
         line_q <= 256'd0;
      end else begin
         if (start_rd || start_wr) begin
            addr <= {bus.address_i[31:5], 5'd0};
         end
         if (start_wr) begin
            data <= bus.line_i;
         end
         if (state == READ && beat) begin
            data[{cnt, 6'd0} +: 64] <= bus.burst_i;
            if (last_beat) begin
               line_q <= {bus.burst_i, data[191:0]};
            end
         end
      end
   end

   always_comb begin
      bus.address_o = (state == READ || state == WRITE) ? addr : 32'd0;
      bus.read_o    = (state == READ);
      bus.write_o   = (state == WRITE);
      bus.burst_o   = (state == WRITE) ? cur_beat : 64'd0;
`ifdef ADAPTOR_FAST_RESP_EN
      bus.resp_o    = last_beat;
      bus.line_o    = (last_beat && state == READ) ? {bus.burst_i, data[191:0]} : line_q;
`else
      bus.resp_o    = (state == DONE);
      bus.line_o    = line_q;
`endif
   end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: line_i  input  256  write line from arbiter.
REQ-004 SHALL have ports: line_o  output  256  read line to arbiter.
REQ-005 SHALL have ports: address_i  input  32  line address from arbiter.
REQ-006 SHALL have ports: read_i  input  1  line read request, held until resp_o.
REQ-007 SHALL have ports: write_i  input  1  line write request, held until resp_o.
REQ-008 SHALL have ports: resp_o  output  1  line transaction complete, one-cycle pulse.
REQ-009 SHALL have ports: burst_i  input  64  read beat from memory.
REQ-010 SHALL have ports: burst_o  output  64  write beat to memory.
REQ-011 SHALL have ports: address_o  output  32  burst address to memory.
REQ-012 SHALL have ports: read_o  output  1  burst read request.
REQ-013 SHALL have ports: write_o  output  1  burst write request.
REQ-014 SHALL have ports: resp_i  input  1  memory beat valid or accepted, one per beat.

Function
REQ-015 SHALL implement states IDLE, READ, WRITE and DONE, plus a 2-bit beat counter.
REQ-016 In IDLE: write_i=1 SHALL go to WRITE; read_i=1 with write_i=0 SHALL go to READ; both asserted SHALL be treated as a write.
REQ-017 On leaving IDLE: SHALL latch address_i with bits [4:0] forced to 0, latch line_i on a write, and clear the beat counter.
REQ-018 address_o SHALL drive the latched address in READ and WRITE, and 0 otherwise.
REQ-019 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE.
REQ-020 Beat k SHALL map to line bits [64k+63:64k], k = 0..3, in ascending order.
REQ-021 In READ, each cycle with resp_i=1 SHALL store burst_i into beat[counter] and increment the counter.
REQ-022 In WRITE, burst_o SHALL present latched beat[counter], and each resp_i=1 SHALL increment the counter; burst_o SHALL be 0 outside WRITE.
REQ-023 Cycles with resp_i=0 inside a burst SHALL stall the counter and hold all outputs.
REQ-024 resp_i=1 with counter=3 SHALL move READ or WRITE to DONE.
REQ-025 DONE SHALL last one cycle with resp_o=1, then return to IDLE unconditionally; requests in DONE SHALL be ignored.
REQ-026 line_o SHALL hold the last assembled read line until the next read completes.
REQ-027 resp_i in IDLE or DONE SHALL be ignored.
REQ-028 With zero memory stalls, read and write latency SHALL be 6 cycles from the request edge to the resp_o cycle.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, counter=0, latched address=0, and line registers=0.
REQ-030 During reset, all outputs SHALL be 0.
REQ-031 Reset mid-burst SHALL discard partial data and SHALL NOT produce resp_o.

Configuration
REQ-032 The macro ADAPTOR_FAST_RESP_EN SHALL, when defined, assert resp_o in the cycle the fourth beat arrives or is accepted, skipping DONE.
REQ-033 With ADAPTOR_FAST_RESP_EN defined, line_o SHALL be combinational in that cycle, equal to {burst_i, beat2, beat1, beat0}, and latency SHALL be 5 cycles.
REQ-034 With ADAPTOR_FAST_RESP_EN defined, the cycle after the fast response SHALL be IDLE but ignore requests for one cycle.
REQ-035 With ADAPTOR_FAST_RESP_EN undefined, behaviour SHALL be exactly REQ-024 to REQ-028.

Verification
REQ-036 Read test: read_i with address_i=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back.
  -> address_o=0x0000_1220; resp_o pulses once; line_o={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
REQ-037 Write test: write_i with line_i=0xDEADBEEF pattern; memory accepts beats with one-cycle gaps.
  -> burst_o steps through beats 0..3 only on resp_i; write_o drops after the 4th beat; resp_o pulses once.
REQ-038 Simultaneous test: read_i=1 and write_i=1 in IDLE.
  -> write_o=1 and read_o=0.
REQ-039 Reset test: assert rst after 2 read beats.
  -> outputs go 0 without waiting for a clock; no resp_o; a subsequent read completes correctly.
REQ-040 Stray-response test: resp_i=1 while in IDLE.
  -> no state change and no resp_o.
REQ-041 Fast-response test: rerun the read test with ADAPTOR_FAST_RESP_EN defined.
  -> resp_o coincides with the 4th beat; latency is 5 cycles.
